// File: rtl/pulse_conditioner_pkg.sv
// Shared state encoding, output levels and the 17-to-16 bit saturation helper
// for the pulse_conditioner front-end discriminator.
package pulse_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        ACTIVE = 2'd2,
        DEAD   = 2'd3
    } state_t;

    localparam logic signed [15:0] HI_LVL = 16'sh7FFF;
    localparam logic signed [15:0] LO_LVL = 16'sh0000;

    // A 17-bit difference overflows 16 bits exactly when its top two bits disagree.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] value);
        logic signed [15:0] res;
        if (value[16] != value[15]) begin
            res = value[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            res = value[15:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pulse_conditioner_baseline_tracker.sv
// First-order IIR baseline estimator: acc moves by (sample - baseline) each
// unfrozen cycle, and the baseline is acc scaled down by 2**BASE_SHIFT.
module baseline_tracker
    import pulse_conditioner_pkg::*;
#(
    parameter int BASE_SHIFT = 6
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Freeze,
    input  logic signed [15:0] Sample,
    output logic signed [15:0] Baseline
);

    localparam int ACC_W = 17 + BASE_SHIFT;

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] sample_ext_s;
    logic signed [ACC_W-1:0] base_ext_s;

    // Arithmetic shift followed by truncation to 16 bits is a plain bit slice.
    assign Baseline     = acc_r[BASE_SHIFT +: 16];
    assign sample_ext_s = {{(ACC_W-16){Sample[15]}}, Sample};
    assign base_ext_s   = {{(ACC_W-16){Baseline[15]}}, Baseline};

    // Accumulator register, held while a pulse is being qualified or emitted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc_r <= '0;
        end else if (!Freeze) begin
            acc_r <= acc_r + sample_ext_s - base_ext_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/pulse_conditioner.sv
// Baseline-corrected, glitch-filtered hysteresis discriminator with dead time.
// Define PULSE_COND_BASELINE_EN to build the baseline tracker; otherwise Baseline is 0.
module pulse_conditioner
    import pulse_conditioner_pkg::*;
#(
    parameter int BASE_SHIFT = 6
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic signed [15:0] DataIn,
    input  logic signed [15:0] ThresholdHi,
    input  logic signed [15:0] ThresholdLo,
    input  logic        [7:0]  GlitchLen,
    input  logic        [15:0] DeadTime,
    output logic signed [15:0] DataOut,
    output logic               PulseActive,
    output logic signed [15:0] Baseline
);

    if ((BASE_SHIFT < 1) || (BASE_SHIFT > 12)) begin : g_bad_shift
        $error("pulse_conditioner: BASE_SHIFT must lie in 1..12");
    end

    state_t             state_r;
    state_t             state_nxt_s;
    logic        [7:0]  gcnt_r;
    logic        [7:0]  gcnt_nxt_s;
    logic        [15:0] dcnt_r;
    logic        [15:0] dcnt_nxt_s;
    logic signed [15:0] d1_r;
    logic signed [15:0] c_r;
    logic signed [15:0] c_nxt_s;

`ifdef PULSE_COND_BASELINE_EN
    logic freeze_s;

    assign freeze_s = (state_r != IDLE);

    baseline_tracker #(
        .BASE_SHIFT (BASE_SHIFT)
    ) u_baseline (
        .Clk      (Clk),
        .Reset    (Reset),
        .Freeze   (freeze_s),
        .Sample   (d1_r),
        .Baseline (Baseline)
    );

    assign c_nxt_s = sat16($signed({d1_r[15], d1_r}) - $signed({Baseline[15], Baseline}));
`else
    assign Baseline = 16'sd0;
    assign c_nxt_s  = d1_r;
`endif

    // Sample pipeline, corrected sample and FSM state/counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            d1_r    <= 16'sd0;
            c_r     <= 16'sd0;
            state_r <= IDLE;
            gcnt_r  <= 8'd0;
            dcnt_r  <= 16'd0;
        end else begin
            d1_r    <= DataIn;
            c_r     <= c_nxt_s;
            state_r <= state_nxt_s;
            gcnt_r  <= gcnt_nxt_s;
            dcnt_r  <= dcnt_nxt_s;
        end
    end

    // Next-state logic; thresholds and counts are taken live each cycle.
    always_comb begin
        state_nxt_s = state_r;
        gcnt_nxt_s  = gcnt_r;
        dcnt_nxt_s  = dcnt_r;
        case (state_r)
            IDLE: begin
                if (c_r > ThresholdHi) begin
                    if (GlitchLen == 8'd0) begin
                        state_nxt_s = ACTIVE;
                    end else begin
                        state_nxt_s = ARMING;
                        gcnt_nxt_s  = 8'd1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARMING: begin
                // Only equality fires, so a GlitchLen lowered below gcnt waits for the 8-bit wrap.
                if (c_r <= ThresholdHi) begin
                    state_nxt_s = IDLE;
                end else if (gcnt_r == GlitchLen) begin
                    state_nxt_s = ACTIVE;
                end else begin
                    gcnt_nxt_s = gcnt_r + 8'd1;
                end
            end
            ACTIVE: begin
                if (c_r < ThresholdLo) begin
                    if (DeadTime == 16'd0) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DEAD;
                        dcnt_nxt_s  = 16'd0;
                    end
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            DEAD: begin
                dcnt_nxt_s = dcnt_r + 16'd1;
                if (dcnt_r == (DeadTime - 16'd1)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DEAD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Two-level output decoded from the registered state.
    always_comb begin
        DataOut     = LO_LVL;
        PulseActive = 1'b0;
        if (state_r == ACTIVE) begin
            DataOut     = HI_LVL;
            PulseActive = 1'b1;
        end else begin
            DataOut     = LO_LVL;
            PulseActive = 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_conditioner.sv
// Self-checking bench for pulse_conditioner: a behavioural model stepped on each
// rising edge and compared on each falling edge, plus directed literal checks.
module tb_pulse_conditioner;

    localparam int BASE_SHIFT = 6;
`ifdef PULSE_COND_BASELINE_EN
    localparam bit BL_EN = 1'b1;
`else
    localparam bit BL_EN = 1'b0;
`endif

    logic               Clk         = 1'b0;
    logic               Reset       = 1'b1;
    logic signed [15:0] DataIn      = 16'sd0;
    logic signed [15:0] ThresholdHi = 16'sd1000;
    logic signed [15:0] ThresholdLo = 16'sd500;
    logic        [7:0]  GlitchLen   = 8'd0;
    logic        [15:0] DeadTime    = 16'd0;
    logic signed [15:0] DataOut;
    logic               PulseActive;
    logic signed [15:0] Baseline;

    int n_cmp = 0;
    int n_err = 0;
    bit model_on = 1'b0;

    // Model: pipeline values, baseline accumulator, and pulse bookkeeping
    // (active flag, length of the current above-Hi run, dead cycles remaining).
    int     d1_m   = 0;
    int     c_m    = 0;
    longint acc_m  = 0;
    bit     act_m  = 1'b0;
    int     run_m  = 0;
    int     dead_m = 0;

    pulse_conditioner #(.BASE_SHIFT(BASE_SHIFT)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DataIn      (DataIn),
        .ThresholdHi (ThresholdHi),
        .ThresholdLo (ThresholdLo),
        .GlitchLen   (GlitchLen),
        .DeadTime    (DeadTime),
        .DataOut     (DataOut),
        .PulseActive (PulseActive),
        .Baseline    (Baseline)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int bl_of(input longint a);
        return BL_EN ? int'(shortint'(a >>> BASE_SHIFT)) : 0;
    endfunction

    task automatic model_step();
        int bl;
        int hi;
        int lo;
        int gl;
        int dt;
        bit idle;
        if (Reset) begin
            d1_m = 0; c_m = 0; acc_m = 0; act_m = 1'b0; run_m = 0; dead_m = 0;
        end else begin
            hi   = int'(ThresholdHi);
            lo   = int'(ThresholdLo);
            gl   = int'(GlitchLen);
            dt   = int'(DeadTime);
            idle = !act_m && (run_m == 0) && (dead_m == 0);
            bl   = bl_of(acc_m);
            if (dead_m > 0) begin
                dead_m--;
            end else if (act_m) begin
                if (c_m < lo) begin
                    act_m  = 1'b0;
                    dead_m = dt;
                end
            end else if (run_m > 0) begin
                if (c_m <= hi) run_m = 0;
                else if (run_m == gl) begin act_m = 1'b1; run_m = 0; end
                else run_m++;
            end else if (c_m > hi) begin
                if (gl == 0) act_m = 1'b1;
                else run_m = 1;
            end
            if (idle) acc_m += longint'(d1_m - bl);
            c_m  = sat(d1_m - bl);
            d1_m = int'(DataIn);
        end
    endtask

    task automatic compare();
        chk("m_dataout", DataOut, act_m ? 32767 : 0);
        chk("m_active", PulseActive, act_m ? 1 : 0);
        chk("m_baseline", Baseline, bl_of(acc_m));
    endtask

    // Single compare process: step the model on the rising edge, check on the falling one.
    initial begin
        forever begin
            @(posedge Clk);
            model_step();
            @(negedge Clk);
            if (model_on) compare();
        end
    end

    task automatic do_reset();
        Reset  = 1'b1;
        DataIn = 16'sd0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    // Edge e counts rising edges after the call; window values are presented before edge e.
    task automatic seq_check(input string nm, input int n,
                             input int w1s, input int w1e, input int v1,
                             input int w2s, input int w2e, input int v2,
                             input int w3s, input int w3e, input int v3,
                             input int vf,
                             input int a0, input int a1, input int b0, input int b1);
        bit exp_act;
        for (int e = 1; e <= n; e++) begin
            if ((e >= w1s) && (e <= w1e))      DataIn = 16'(v1);
            else if ((e >= w2s) && (e <= w2e)) DataIn = 16'(v2);
            else if ((e >= w3s) && (e <= w3e)) DataIn = 16'(v3);
            else                               DataIn = 16'(vf);
            @(negedge Clk);
            exp_act = ((e >= a0) && (e <= a1)) || ((e >= b0) && (e <= b1));
            chk({nm, "_active"}, PulseActive, exp_act ? 1 : 0);
            chk({nm, "_dataout"}, DataOut, exp_act ? 32767 : 0);
        end
    endtask

    initial begin
        int bl_hold;

        // Reset held five cycles with a large input.
        Reset  = 1'b1;
        DataIn = 16'sh4000;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            model_on = 1'b1;
            chk("rst_dataout", DataOut, 0);
            chk("rst_active", PulseActive, 0);
            chk("rst_baseline", Baseline, 0);
        end
        Reset       = 1'b0;
        ThresholdHi = 16'sh7000;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("post_rst_no_pulse", PulseActive, 0);
        end

        // Glitch filter with GlitchLen = 2.
        ThresholdHi = 16'sd1000; ThresholdLo = 16'sd500; GlitchLen = 8'd2; DeadTime = 16'd0;
        do_reset();
        seq_check("glitch2", 12, 1, 2, 5000, 0, -1, 0, 0, -1, 0, 0, 0, -1, 0, -1);
        do_reset();
        seq_check("glitch3", 12, 1, 3, 5000, 0, -1, 0, 0, -1, 0, 0, 5, 5, 0, -1);

        // Hysteresis: 700 sits between Lo and Hi, 400 releases.
        GlitchLen = 8'd0;
        do_reset();
        seq_check("hyst", 30, 1, 3, 5000, 4, 23, 700, 0, -1, 0, 400, 3, 25, 0, -1);

        // Dead time of 10: a pulse inside the window is ignored, a later one accepted.
        DeadTime = 16'd10;
        do_reset();
        seq_check("dead", 30, 1, 3, 5000, 11, 13, 5000, 18, 20, 5000, 0, 3, 5, 20, 22);

`ifdef PULSE_COND_BASELINE_EN
        // Baseline settles on a constant input, then freezes during a pulse.
        ThresholdHi = 16'sd3000; ThresholdLo = 16'sd1000; GlitchLen = 8'd0; DeadTime = 16'd10;
        do_reset();
        DataIn = 16'sd2000;
        repeat (1500) @(negedge Clk);
        chk("bl_settled_ge_1937", (Baseline >= 16'sd1937) ? 1 : 0, 1);
        chk("bl_settled_le_2000", (Baseline <= 16'sd2000) ? 1 : 0, 1);
        chk("bl_no_pulse", PulseActive, 0);
        bl_hold = 0;
        for (int e = 1; e <= 30; e++) begin
            DataIn = (e <= 10) ? 16'sd6000 : 16'sd2000;
            @(negedge Clk);
            chk("bl_step_active", PulseActive, ((e >= 3) && (e <= 12)) ? 1 : 0);
            if (e == 3) bl_hold = bl_of(acc_m);
            if ((e >= 4) && (e <= 23)) chk("bl_frozen", Baseline, bl_hold);
        end
        DataIn = 16'sd2000;
        repeat (100) @(negedge Clk);
        // Full-scale negative input must saturate rather than wrap to a large positive value.
        DataIn = 16'sh8000;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("sat_no_pulse", PulseActive, 0);
        end
`endif

        // Reset asserted in the middle of a pulse.
        ThresholdHi = 16'sd1000; ThresholdLo = 16'sd500; GlitchLen = 8'd0; DeadTime = 16'd0;
        do_reset();
        DataIn = 16'sd5000;
        repeat (3) @(negedge Clk);
        chk("midrst_pre_active", PulseActive, 1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_dataout", DataOut, 0);
        chk("midrst_active", PulseActive, 0);
        chk("midrst_baseline", Baseline, 0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("midrst_reaccept", PulseActive, 1);

        // Randomized segments against the model.
        for (int seg = 0; seg < 8; seg++) begin
            int hi;
            int lo;
            int burst;
            int r;
            int v;
            hi = int'($urandom_range(4000, 200));
            lo = (seg == 5) ? hi + 300 : int'($urandom_range(32'(hi), 0));
            ThresholdHi = 16'(hi);
            ThresholdLo = 16'(lo);
            GlitchLen   = 8'($urandom_range(4, 0));
            DeadTime    = 16'($urandom_range(8, 0));
            do_reset();
            burst = 0;
            for (int k = 0; k < 300; k++) begin
                r = int'($urandom_range(99, 0));
                if (burst > 0) begin
                    v = hi + int'($urandom_range(3000, 1));
                    burst--;
                end else if (r < 8) begin
                    burst = int'($urandom_range(8, 1));
                    v = hi + int'($urandom_range(3000, 1));
                end else if (r == 8) begin
                    v = 32767;
                end else if (r == 9) begin
                    v = -32768;
                end else begin
                    v = int'($urandom_range(32'(hi + 400), 0)) - 200;
                end
                DataIn = 16'(v);
                if ((k % 64) == 63) begin
                    hi = hi + int'($urandom_range(200, 0)) - 100;
                    ThresholdHi = 16'(hi);
                end
                @(negedge Clk);
            end
        end

        @(negedge Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
